// File: rtl/intdiv_sd2conv_if.sv
// Digit-in / result-out handshake bundle for the SD2 to two's-complement converter.
interface intdiv_sd2conv_if #(
  parameter int unsigned N = 8
) ();
  logic         start;
  logic         dig_valid;
  logic [1:0]   dig;
  logic         dig_ready;
  logic [N:0]   q;
  logic         q_valid;
  logic         q_ready;
  logic         busy;
  logic         q_zero;

  modport slave (
    input  start, dig_valid, dig, q_ready,
    output dig_ready, q, q_valid, busy, q_zero
  );

  modport master (
    output start, dig_valid, dig, q_ready,
    input  dig_ready, q, q_valid, busy, q_zero
  );
endinterface

// File: rtl/intdiv_sd2conv.sv
// On-the-fly conversion of N signed-binary (SD2) quotient digits, MSB first,
// into an (N+1)-bit two's-complement result using the Q / Q-1 register pair.
module intdiv_sd2conv #(
  parameter int unsigned N = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  intdiv_sd2conv_if.slave    bus
);

  localparam int unsigned W  = N + 1;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [W-1:0]  q_reg;
  logic [W-1:0]  qm_reg;
  logic [W-1:0]  q_nxt;
  logic [W-1:0]  qm_nxt;

  // Next Q / QM for the presented digit; the MSB falls off the top.
  always_comb begin
    q_nxt  = {q_reg[W-2:0], 1'b0};
    qm_nxt = {qm_reg[W-2:0], 1'b1};
    unique case (bus.dig)
      2'b10: begin
        q_nxt  = {q_reg[W-2:0], 1'b1};
        qm_nxt = {q_reg[W-2:0], 1'b0};
      end
      2'b01: begin
        q_nxt  = {qm_reg[W-2:0], 1'b1};
        qm_nxt = {qm_reg[W-2:0], 1'b0};
      end
      default: ;
    endcase
  end

  // Control FSM; every output is registered alongside the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      q_reg         <= '0;
      qm_reg        <= '1;
      bus.q         <= '0;
      bus.q_valid   <= 1'b0;
      bus.dig_ready <= 1'b0;
      bus.busy      <= 1'b0;
      bus.q_zero    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state         <= CONV;
            cnt           <= '0;
            q_reg         <= '0;
            qm_reg        <= '1;
            bus.dig_ready <= 1'b1;
            bus.busy      <= 1'b1;
          end
        end
        CONV: begin
          if (bus.start) begin
            // Restart wins over any digit presented in the same cycle.
            cnt    <= '0;
            q_reg  <= '0;
            qm_reg <= '1;
          end else if (bus.dig_valid) begin
            q_reg  <= q_nxt;
            qm_reg <= qm_nxt;
            if (cnt == CW'(N - 1)) begin
              state         <= DONE;
              bus.q         <= q_nxt;
              bus.q_zero    <= (q_nxt == '0);
              bus.q_valid   <= 1'b1;
              bus.dig_ready <= 1'b0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        DONE: begin
          if (bus.q_ready) begin
            bus.q_valid <= 1'b0;
            bus.q_zero  <= 1'b0;
            if (bus.start) begin
              state         <= CONV;
              cnt           <= '0;
              q_reg         <= '0;
              qm_reg        <= '1;
              bus.dig_ready <= 1'b1;
            end else begin
              state    <= IDLE;
              bus.busy <= 1'b0;
            end
          end
        end
        default: begin
          state         <= IDLE;
          bus.dig_ready <= 1'b0;
          bus.busy      <= 1'b0;
          bus.q_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_intdiv_sd2conv.sv
// Self-checking bench for intdiv_sd2conv with N = 4: directed vectors, corner
// sequences and randomized conversions against an arithmetic digit-sum model.
module tb_intdiv_sd2conv;

  localparam int unsigned N = 4;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  intdiv_sd2conv_if #(.N(N)) bus ();

  intdiv_sd2conv #(.N(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] digs;
    logic [4:0] q;
    logic       z;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Signed sum of digit values weighted 8,4,2,1, wrapped to 5 bits.
  function automatic logic [4:0] model_q(input logic [7:0] digs);
    int v;
    logic [1:0] d;
    v = 0;
    for (int k = 0; k < 4; k++) begin
      d = digs[7-2*k -: 2];
      v += (int'(d[1]) - int'(d[0])) * (1 << (3 - k));
    end
    return 5'(v);
  endfunction

  task automatic start_pulse();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic feed_and_check(input logic [7:0] digs, input logic [4:0] exp_q,
                                input logic exp_z, input int max_gap, input string tag);
    int t;
    for (int k = 0; k < 4; k++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        bus.dig_valid = 1'b0;
        bus.dig       = 2'($urandom);
        @(negedge clk);
      end
      check({tag, "_dig_ready"}, 32'(bus.dig_ready), 32'd1);
      bus.dig_valid = 1'b1;
      bus.dig       = digs[7-2*k -: 2];
      @(negedge clk);
    end
    bus.dig_valid = 1'b0;
    check({tag, "_latency"}, 32'(bus.q_valid), 32'd1);
    t = 0;
    while (!bus.q_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_q"}, 32'(bus.q), 32'(exp_q));
    check({tag, "_q_zero"}, 32'(bus.q_zero), 32'(exp_z));
  endtask

  task automatic pop(input string tag);
    bus.q_ready = 1'b1;
    @(negedge clk);
    bus.q_ready = 1'b0;
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
    check({tag, "_idle_q_valid"}, 32'(bus.q_valid), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] rd;
    logic [4:0] mq;
    checks = 0;
    errors = 0;
    vecs[0] = '{digs: 8'b10_00_01_10, q: 5'b00111, z: 1'b0};
    vecs[1] = '{digs: 8'b01_01_01_01, q: 5'b10001, z: 1'b0};
    vecs[2] = '{digs: 8'b00_10_01_01, q: 5'b00001, z: 1'b0};
    vecs[3] = '{digs: 8'b10_11_01_01, q: 5'b00101, z: 1'b0};
    vecs[4] = '{digs: 8'b11_00_00_11, q: 5'b00000, z: 1'b1};
    vecs[5] = '{digs: 8'b10_01_01_01, q: 5'b00001, z: 1'b0};

    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.dig_valid = 1'b0;
    bus.dig = 2'b00;
    bus.q_ready = 1'b0;
    #12;
    check("rst_q", 32'(bus.q), 32'd0);
    check("rst_q_valid", 32'(bus.q_valid), 32'd0);
    check("rst_dig_ready", 32'(bus.dig_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_q_zero", 32'(bus.q_zero), 32'd0);

    // Start on the same cycle reset releases must be honoured.
    @(negedge clk);
    rst_n = 1'b1;
    start_pulse();
    check("first_start_busy", 32'(bus.busy), 32'd1);
    check("first_start_ready", 32'(bus.dig_ready), 32'd1);
    feed_and_check(vecs[0].digs, vecs[0].q, vecs[0].z, 0, "first");
    pop("first");

    // Digits offered while idle are ignored.
    bus.dig_valid = 1'b1;
    bus.dig = 2'b10;
    repeat (2) @(negedge clk);
    bus.dig_valid = 1'b0;
    check("idle_dig_busy", 32'(bus.busy), 32'd0);
    check("idle_dig_ready", 32'(bus.dig_ready), 32'd0);
    check("idle_dig_q_valid", 32'(bus.q_valid), 32'd0);

    for (int i = 0; i < 6; i++) begin
      start_pulse();
      feed_and_check(vecs[i].digs, vecs[i].q, vecs[i].z, 0, $sformatf("vec%0d", i));
      pop($sformatf("vec%0d", i));
    end

    // Result held in DONE under back-pressure; start without q_ready ignored.
    start_pulse();
    feed_and_check(vecs[0].digs, vecs[0].q, vecs[0].z, 0, "hold");
    for (int i = 0; i < 3; i++) begin
      bus.dig_valid = 1'b1;
      bus.dig = 2'b01;
      bus.start = (i == 1);
      @(negedge clk);
      check("hold_q", 32'(bus.q), 32'h07);
      check("hold_q_valid", 32'(bus.q_valid), 32'd1);
      check("hold_dig_ready", 32'(bus.dig_ready), 32'd0);
      check("hold_q_zero", 32'(bus.q_zero), 32'd0);
    end
    bus.dig_valid = 1'b0;
    bus.start = 1'b1;
    bus.q_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.q_ready = 1'b0;
    check("restart_busy", 32'(bus.busy), 32'd1);
    check("restart_dig_ready", 32'(bus.dig_ready), 32'd1);
    check("restart_q_valid", 32'(bus.q_valid), 32'd0);
    feed_and_check(vecs[3].digs, vecs[3].q, vecs[3].z, 0, "restart");
    pop("restart");

    // Abort mid-conversion; the digit beside the second start is dropped.
    start_pulse();
    bus.dig_valid = 1'b1;
    bus.dig = 2'b10;
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    feed_and_check(8'b00_00_00_10, 5'b00001, 1'b0, 0, "abort");
    pop("abort");

    // Asynchronous reset between edges mid-conversion.
    start_pulse();
    bus.dig_valid = 1'b1;
    bus.dig = 2'b10;
    repeat (2) @(negedge clk);
    bus.dig_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_q", 32'(bus.q), 32'd0);
    check("arst_q_valid", 32'(bus.q_valid), 32'd0);
    check("arst_dig_ready", 32'(bus.dig_ready), 32'd0);
    check("arst_busy", 32'(bus.busy), 32'd0);
    check("arst_q_zero", 32'(bus.q_zero), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_no_q_valid", 32'(bus.q_valid), 32'd0);
    start_pulse();
    feed_and_check(vecs[1].digs, vecs[1].q, vecs[1].z, 0, "after_rst");
    pop("after_rst");

    // Randomized conversions with idle gaps and delayed consumption.
    for (int r = 0; r < 40; r++) begin
      rd = 8'($urandom);
      mq = model_q(rd);
      start_pulse();
      feed_and_check(rd, mq, (mq == 5'd0), 2, $sformatf("rnd%0d", r));
      repeat ($urandom_range(2, 0)) @(negedge clk);
      check($sformatf("rnd%0d_stable", r), 32'(bus.q), 32'(mq));
      pop($sformatf("rnd%0d", r));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intdiv_sd2conv.md
INTDIV_SD2CONV -- requirements
Module: intdiv_sd2conv

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-002 The block SHALL have parameter N, default 8, giving the number of SD2 quotient digits per conversion (N >= 2).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: begins a new conversion.
REQ-006 The block SHALL have port dig_valid, input, 1 bit: dig carries a valid digit.
REQ-007 The block SHALL have port dig, input, 2 bits: one SD2 digit, MSB first, from the overflow-correction stage, in (p,n) encoding.
REQ-008 The block SHALL have port dig_ready, output, 1 bit: the block accepts a digit this cycle.
REQ-009 The block SHALL have port q, output, N+1 bits: the two's-complement result.
REQ-010 The block SHALL have port q_valid, output, 1 bit: q holds a completed result.
REQ-011 The block SHALL have port q_ready, input, 1 bit: the consumer takes q.
REQ-012 The block SHALL have port busy, output, 1 bit: the block is not IDLE.
REQ-013 The block SHALL have port q_zero, output, 1 bit: the completed result equals zero; it is valid only while q_valid=1.

Function
REQ-014 The block SHALL decode each digit as value = dig[1] - dig[0], so 2'b10 = +1, 2'b01 = -1, and 2'b00 or 2'b11 = 0. No digit code is illegal.
REQ-015 The block SHALL weight the k-th accepted digit (k = 0..N-1) as 2^(N-1-k), giving a result range of -(2^N-1)..+(2^N-1).
REQ-016 The block SHALL hold two N+1-bit registers, Q and QM, where QM always equals Q-1.
REQ-017 On start, the block SHALL set Q = 0 and QM = all ones.
REQ-018 On each digit handshake, the block SHALL update the registers as follows:
- d = +1: Q <= {Q,1}, QM <= {Q,0}.
- d = 0: Q <= {Q,0}, QM <= {QM,1}.
- d = -1: Q <= {QM,1}, QM <= {QM,0}.
- In every case the MSB is shifted out.
REQ-019 The block SHALL have states IDLE, CONV and DONE, with a digit counter cnt of width clog2(N).
REQ-020 In IDLE, start SHALL cause a transition to CONV, initialise per REQ-017 and set cnt = 0.
REQ-021 A digit handshake SHALL occur when state = CONV and dig_valid = 1 and dig_ready = 1. dig_ready SHALL be 1 only in CONV.
REQ-022 On the handshake where cnt = N-1, the block SHALL enter DONE. Otherwise cnt SHALL increment.
REQ-023 The block SHALL assert q_valid the cycle after the N-th handshake, so latency from the last digit to q_valid is 1 cycle.
REQ-024 In DONE, q_valid SHALL be 1, q SHALL equal Q, and q and q_zero SHALL be held stable until q_ready = 1.
REQ-025 In DONE, if q_ready = 1 and start = 0, the block SHALL go to IDLE.
REQ-026 In DONE, if q_ready = 1 and start = 1, the block SHALL go directly to CONV, re-initialised per REQ-020.
REQ-027 In DONE, start with q_ready = 0 SHALL be ignored.
REQ-028 In CONV, start SHALL abort the conversion and restart per REQ-020. A digit presented in that same cycle SHALL be discarded.
REQ-029 In IDLE, dig_valid SHALL be ignored and no state SHALL change.
REQ-030 busy SHALL be 1 in CONV and DONE, and 0 in IDLE.
REQ-031 q_zero SHALL equal (Q == 0) and SHALL be driven from registered state only.
REQ-032 q SHALL be a direct register output, with no combinational path from dig.

Reset
REQ-033 While rst_n = 0, regardless of clk, the block SHALL force:
- state = IDLE, cnt = 0;
- Q = 0, QM = all ones;
- q = 0, q_valid = 0, dig_ready = 0, busy = 0, q_zero = 0.
REQ-034 Reset asserted mid-CONV or in DONE SHALL discard the conversion with no q_valid pulse.
REQ-035 After rst_n deasserts, the first start SHALL be honoured on the first rising clk edge.

Verification (N = 4)
REQ-036 start, then digits 10,00,01,10 (+1,0,-1,+1) back-to-back -> q_valid 1 cycle after the 4th digit, q = 5'b00111 (+7), q_zero = 0.
REQ-037 start, then digits 01,01,01,01 -> q = 5'b10001 (-15); a second run with digits 00,10,01,01 -> q = 5'b00001 (+1).
REQ-038 start, then digits 10,11,01,01 (+8-2-1 = +5) -> q = 5'b00101. A separate run with digits 10,01,01,01 (+8-4-2-1 = +1) -> q = 5'b00001. Between the two runs, a run with digits 11,00,00,11 -> q = 0, q_zero = 1.
REQ-039 Hold q_ready = 0 for 3 cycles in DONE with dig_valid = 1 -> q and q_valid stable, dig_ready = 0. Then q_ready = 1 together with start = 1 -> CONV the next cycle, busy = 1.
REQ-040 start, 2 digits (+1,+1), then start again, then digits 00,00,00,10 -> q = 5'b00001; the aborted digits have no effect.
REQ-041 rst_n pulsed low mid-CONV between clock edges -> all outputs 0 immediately. The next full conversion is correct.
